// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst master.
// Takes one burst request at a time and runs AW->W->B or AR->R,
// streaming beats through pass-through valid/ready ports.
//
// state  | meaning
// S_IDLE | ready for a request, done/err of last request visible
// S_AW   | write address presented, waiting for awready
// S_W    | write beats streaming, wlast on count==len
// S_B    | waiting for write response
// S_AR   | read address presented, waiting for arready
// S_R    | read beats streaming, rd_last on count==len
module axi_burst_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] AXI_ID     = 3'd0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  // request port
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [7:0]            i_req_len,
  // write beat port
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [STRB_WIDTH-1:0] i_wr_strb,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  // read beat port
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  // status
  output logic                  o_done,
  output logic                  o_err,
  // AXI AW
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic [2:0]            o_awid,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  // AXI W
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_WIDTH-1:0] o_wstrb,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  // AXI B
  input  logic [1:0]            i_bresp,
  input  logic [2:0]            i_bid,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  // AXI AR
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic [2:0]            o_arid,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  // AXI R
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic [2:0]            i_rid,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic                  r_done;

  logic w_accept;
  logic w_wbeat;
  logic w_rbeat;
  logic w_bhs;
  logic w_last;
  logic w_r_err;
  logic w_b_err;

  assign w_accept = (r_state == S_IDLE) && i_req_valid;
  assign w_wbeat  = (r_state == S_W) && i_wr_valid && i_wready;
  assign w_rbeat  = (r_state == S_R) && i_rvalid && i_rd_ready;
  assign w_bhs    = (r_state == S_B) && i_bvalid;
  assign w_last   = (r_cnt == r_len);
  assign w_r_err  = (i_rresp != 2'b00) || (i_rid != AXI_ID) || (i_rlast != w_last);
  assign w_b_err  = (i_bresp != 2'b00) || (i_bid != AXI_ID);

  // Address channels come straight from the latched request so they stay stable.
  assign o_awaddr  = r_addr;
  assign o_awlen   = r_len;
  assign o_awsize  = 3'b010;
  assign o_awburst = 2'b01;
  assign o_awid    = AXI_ID;
  assign o_araddr  = r_addr;
  assign o_arlen   = r_len;
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_arid    = AXI_ID;
  assign o_wdata   = i_wr_data;
  assign o_wstrb   = i_wr_strb;
  assign o_rd_data = i_rdata;
  assign o_done    = r_done;
  assign o_err     = r_err;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and per-state handshake routing.
  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_awvalid   = 1'b0;
    o_arvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_wr_ready  = 1'b0;
    o_wlast     = 1'b0;
    o_bready    = 1'b0;
    o_rd_valid  = 1'b0;
    o_rready    = 1'b0;
    o_rd_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = i_req_write ? S_AW : S_AR;
      end
      S_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) w_next = S_W;
      end
      S_W: begin
        o_wvalid   = i_wr_valid;
        o_wr_ready = i_wready;
        o_wlast    = w_last;
        if (w_wbeat && w_last) w_next = S_B;
      end
      S_B: begin
        o_bready = 1'b1;
        if (i_bvalid) w_next = S_IDLE;
      end
      S_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_next = S_R;
      end
      S_R: begin
        o_rd_valid = i_rvalid;
        o_rready   = i_rd_ready;
        o_rd_last  = w_last;
        if (w_rbeat && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, beat counter, error accumulation and done pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_addr <= i_req_addr & ADDR_MASK;
        r_len  <= i_req_len;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      // The last beat leaves the counter alone so it never wraps past 255.
      if ((w_wbeat || w_rbeat) && !w_last) r_cnt <= r_cnt + 8'd1;
      if (w_rbeat) begin
        r_err  <= r_err | w_r_err;
        r_done <= w_last;
      end
      if (w_bhs) begin
        r_err  <= r_err | w_b_err;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

AXI4 master that turns single-request burst commands from a cache/refill engine into complete INCR write or read bursts on a 32-bit AXI4 port with 3-bit IDs. It sits directly upstream of the simulation AXI RAM and other AXI slaves, owning one transaction at a time (AW→W→B or AR→R). Write data and read data stream through valid/ready ports with beat counting. Completion and error status are reported per request.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (fixed 32)
- STRB_WIDTH, DATA_WIDTH/8, byte strobes
- AXI_ID, 3'd0, value driven on awid/arid and expected on bid/rid
---
- Clock/reset (already decided): one clock; reset is synchronous and active-low.
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- req_valid / req_ready  in / out  1 / 1  request handshake; req_ready = (state==IDLE)
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  start byte address; bits [1:0] forced to 0 on AXI
- req_len  in  8  beats minus one (0..255)
- wr_data / wr_strb  in  DATA_WIDTH / STRB_WIDTH  write beat payload
- wr_valid / wr_ready  in / out  1 / 1  write beat handshake
- rd_data  out  DATA_WIDTH  read beat payload (= rdata)
- rd_last  out  1  final beat of request (internal counter)
- rd_valid / rd_ready  out / in  1 / 1  read beat handshake
- done  out  1  one-cycle pulse, request complete
- err  out  1  valid with done; 1 = non-OKAY response or ID/last mismatch
- AXI AW: awaddr[ADDR_WIDTH], awlen[8], awsize[3], awburst[2], awid[3] out; awvalid out, awready in
- AXI W: wdata, wstrb, wlast, wvalid out; wready in
- AXI B: bresp[2], bid[3], bvalid in; bready out
- AXI AR: araddr, arlen, arsize, arburst, arid out; arvalid out, arready in
- AXI R: rdata, rresp[2], rid[3], rlast, rvalid in; rready out

## Operation
- States: IDLE, AW, W, B, AR, R.
- IDLE: on req_valid, latch addr (low 2 bits zeroed), len, write flag; clear beat counter and error flag; go to AW (write) or AR (read).
- AW / AR: awvalid/arvalid driven by registered state. awsize=arsize=3'b010, awburst=arburst=2'b01 (INCR), awlen/arlen=latched len, IDs=AXI_ID. Address channel signals are held stable until awready/arready. Handshake moves to W or R.
- W: wvalid=wr_valid, wr_ready=wready, wdata/wstrb=wr_data/wr_strb (combinational pass-through). wlast=(count==len). Each wvalid&wready increments the counter. The wlast beat moves to B.
- B: bready=1. On bvalid, err accumulates (bresp!=0 or bid!=AXI_ID). Go to IDLE and pulse done.
- R: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=(count==len). Each beat increments the counter. err accumulates on rresp!=0, rid!=AXI_ID, or rlast!=rd_last. The beat with count==len goes to IDLE and pulses done.
- Counter is 8 bits and never wraps within a request, because the last beat is count==len≤255.
- Outside W/R, wr_ready, wvalid, rd_valid, and rready are 0. bready is 0 outside B.
- No 4 KiB boundary splitting. Callers guarantee that bursts do not cross 4 KiB.
- Only one outstanding transaction. A new request is not accepted before done.

## Timing
- Reset values: awvalid=arvalid=wvalid=bready=rready=0, wr_ready=rd_valid=0, done=0, err=0, state=IDLE, req_ready=1. awaddr/araddr/awlen/arlen=0.
- Reset mid-operation: next edge forces IDLE and drops all valids/readies. The in-flight AXI transaction is abandoned, and the slave must be reset together.
- Request accepted at edge N → awvalid/arvalid high from cycle N+1.
- First W/R beat is possible the cycle after the address handshake.
- Zero-wait read of len L: done pulses L+3 cycles after acceptance.
- done and err are registered. They are high the cycle after the final B/R handshake, with state already IDLE (req_ready=1). A back-to-back request may be accepted that same cycle.
- err is held stable until the next request acceptance.
- wr_valid low or wready low stalls W with no beat counted. rd_ready low stalls R, with rvalid/rdata held by the slave.

## Test plan
- Write len=3 to 0x100, data 0x11111111..0x44444444, strb 4'hF, slave zero-wait → awlen=3, wlast only on 4th beat, done=1, err=0; RAM words 0x100..0x10C hold the data.
- Read len=3 from 0x100 after the above, rd_ready toggled 1,0,1,0… → rd_data 0x11111111..0x44444444 in order, rd_last only on 4th beat, no beat lost or duplicated, done=1, err=0.
- Single-beat write len=0 to 0x203 (→awaddr 0x200), wr_strb 4'b0011, data 0xAABBCCDD over prior 0xFFFFFFFF → wlast on first beat, RAM word = 0xFFFFCCDD.
- Slave returns bresp=2'b10 (or bid=3'd5) → done=1 with err=1; next clean read gives err=0.
- rstn low for one cycle during W after 2 of 8 beats → next cycle all valids 0, req_ready=1, no done pulse; after slave reset, new len=0 read completes normally.
- Back-to-back: read len=255 then immediate write len=0 → 256 beats with rd_last on beat 256, counter no wrap. Write request accepted in done cycle, awvalid the following cycle.
